// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, ALU codes, FSM states and immediate decode for multi_cycle_core
package core_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_t;

    function automatic logic [31:0] ext_imm(input logic [31:0] ir, input imm_t kind);
        case (kind)
            IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return {{20{ir[31]}}, ir[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - combinational 32-bit ALU for multi_cycle_core
// op: ALU_* code; a, b: operands; result: a op b; zero: result == 0
module mc_alu
    import core_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'd0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
            default: result = 32'd0;
        endcase
        zero = (result == 32'd0);
    end

endmodule

// File: rtl/multi_cycle_core.sv
// rtl/multi_cycle_core.sv - multi-cycle RV32I/RV32E subset core with one shared memory port
// clk, reset (sync, active-low); mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in;
// retire: one-cycle commit pulse; trap: sticky halt on illegal or misaligned operation
module multi_cycle_core
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire,
    output logic        trap
);

    localparam int IDXW = $clog2(NUM_REGS);

    state_t      state, state_nx;
    logic        running;   // low only while reset is held, keeps mem_req off in that window
    logic [31:0] pc, old_pc, ir, a_r, b_r, alu_out, data_r, target;
    logic [31:0] rf [NUM_REGS];

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm, alu_b, alu_result, rf_wdata;
    logic [3:0]  alu_fn, alu_op;
    imm_t        imm_kind;
    logic        legal, bad_reg, use_rs1, use_rs2, use_rd, alu_zero, rf_we;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];
    assign imm    = ext_imm(ir, imm_kind);

    always_comb begin
        imm_kind = IMM_I;
        legal    = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        alu_fn   = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                {use_rs1, use_rs2, use_rd} = 3'b111;
                case ({f7, f3})
                    {F7_BASE, F3_ADD}: begin legal = 1'b1; alu_fn = ALU_ADD; end
                    {F7_SUB,  F3_ADD}: begin legal = 1'b1; alu_fn = ALU_SUB; end
                    {F7_BASE, F3_AND}: begin legal = 1'b1; alu_fn = ALU_AND; end
                    {F7_BASE, F3_OR}:  begin legal = 1'b1; alu_fn = ALU_OR;  end
                    {F7_BASE, F3_SLT}: begin legal = 1'b1; alu_fn = ALU_SLT; end
                    default:           legal = 1'b0;
                endcase
            end
            OP_ITYPE: begin
                {use_rs1, use_rd} = 2'b11;
                case (f3)
                    F3_ADD:  begin legal = 1'b1; alu_fn = ALU_ADD; end
                    F3_AND:  begin legal = 1'b1; alu_fn = ALU_AND; end
                    F3_OR:   begin legal = 1'b1; alu_fn = ALU_OR;  end
                    F3_SLT:  begin legal = 1'b1; alu_fn = ALU_SLT; end
                    default: legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                {use_rs1, use_rd} = 2'b11;
                legal = (f3 == F3_WORD);
            end
            OP_STORE: begin
                {use_rs1, use_rs2} = 2'b11;
                imm_kind = IMM_S;
                legal    = (f3 == F3_WORD);
            end
            OP_BRANCH: begin
                {use_rs1, use_rs2} = 2'b11;
                imm_kind = IMM_B;
                legal    = (f3 == F3_BEQ);
            end
            OP_JAL: begin
                use_rd   = 1'b1;
                imm_kind = IMM_J;
                legal    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // RV32E: any referenced register field with bit 4 set is outside x0..x15
    assign bad_reg = (NUM_REGS < 32) &&
                     ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]));

    // BEQ reuses the ALU as a subtractor so the equality test comes from the zero flag
    assign alu_b  = (state == EXECR || state == BEQ) ? b_r : imm;
    assign alu_op = (state == EXECR || state == EXECI) ? alu_fn :
                    (state == BEQ) ? ALU_SUB : ALU_ADD;

    mc_alu u_alu (
        .op     (alu_op),
        .a      (a_r),
        .b      (alu_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // x0 is never written, so it reads as zero without a read-side mux
    assign rf_we     = (state == ALUWB || state == MEMWB) && (rd != 5'd0);
    assign rf_wdata  = (state == MEMWB) ? data_r : alu_out;
    assign mem_wdata = b_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FETCH;
            running <= 1'b0;
            pc      <= RESET_PC;
            old_pc  <= 32'd0;
            ir      <= 32'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            alu_out <= 32'd0;
            data_r  <= 32'd0;
            target  <= 32'd0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= 32'd0;
        end else begin
            state   <= state_nx;
            running <= 1'b1;
            case (state)
                FETCH: if (mem_req && mem_ready) begin
                    ir     <= mem_rdata;
                    old_pc <= pc;
                    pc     <= pc + 32'd4;
                end
                DECODE: begin
                    a_r    <= rf[rs1[IDXW-1:0]];
                    b_r    <= rf[rs2[IDXW-1:0]];
                    target <= old_pc + imm;
                end
                MEMADR, EXECR, EXECI: alu_out <= alu_result;
                MEMRD: if (mem_ready) data_r <= mem_rdata;
                BEQ:   if (alu_zero) pc <= target;
                JAL: if (target[1:0] == 2'b00) begin
                    alu_out <= old_pc + 32'd4;
                    pc      <= target;
                end
                default: ;
            endcase
            if (rf_we) rf[rd[IDXW-1:0]] <= rf_wdata;
        end
    end

    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = alu_out;
        retire   = 1'b0;
        trap     = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = running;
                mem_addr = pc;
                if (running && mem_ready) state_nx = DECODE;
            end
            DECODE: begin
                if (!legal || bad_reg)              state_nx = TRAP;
                else if (opcode == OP_LOAD ||
                         opcode == OP_STORE)        state_nx = MEMADR;
                else if (opcode == OP_RTYPE)        state_nx = EXECR;
                else if (opcode == OP_ITYPE)        state_nx = EXECI;
                else if (opcode == OP_BRANCH)       state_nx = BEQ;
                else                                state_nx = JAL;
            end
            MEMADR: begin
                if (alu_result[1:0] != 2'b00)       state_nx = TRAP;
                else if (opcode == OP_STORE)        state_nx = MEMWR;
                else                                state_nx = MEMRD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                if (mem_ready) state_nx = MEMWB;
            end
            MEMWB: begin
                retire   = 1'b1;
                state_nx = FETCH;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                // the store commits in the cycle memory accepts it
                if (mem_ready) begin
                    retire   = 1'b1;
                    state_nx = FETCH;
                end
            end
            EXECR, EXECI: state_nx = ALUWB;
            ALUWB: begin
                retire   = 1'b1;
                state_nx = FETCH;
            end
            BEQ: begin
                retire   = 1'b1;
                state_nx = FETCH;
            end
            JAL: state_nx = (target[1:0] != 2'b00) ? TRAP : ALUWB;
            TRAP: begin
                trap     = 1'b1;
                state_nx = TRAP;
            end
            default: state_nx = TRAP;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_core.sv
// tb/tb_multi_cycle_core.sv - directed self-checking bench for multi_cycle_core
module tb_multi_cycle_core;

    logic        clk = 1'b0;
    logic        reset, reset_b;
    logic        mem_req, mem_we, retire, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        mem_req_b, mem_we_b, retire_b, trap_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic        mem_ready_b;

    logic [31:0] mem  [128];
    logic [31:0] memb [128];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int first_fetch = -1;
    int retire_cnt = 0;
    int retire_b_cnt = 0;
    int wait_n = 0;
    int cnt = 0;
    int saved_ret;
    int retire_cyc [$];
    logic [31:0] rd_addr [$];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic        p_req = 1'b0, p_ready = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = 32'd0, p_wdata = 32'd0;
    logic [31:0] exp_rd [11];

    always #5 clk = ~clk;

    multi_cycle_core #(.RESET_PC(32'h0000_0100), .NUM_REGS(32)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .trap      (trap)
    );

    multi_cycle_core #(.RESET_PC(32'h0000_0000), .NUM_REGS(16)) dut_b (
        .clk       (clk),
        .reset     (reset_b),
        .mem_req   (mem_req_b),
        .mem_we    (mem_we_b),
        .mem_addr  (mem_addr_b),
        .mem_wdata (mem_wdata_b),
        .mem_rdata (mem_rdata_b),
        .mem_ready (mem_ready_b),
        .retire    (retire_b),
        .trap      (trap_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    // memory for dut_a: ready after wait_n idle request cycles
    always @(posedge clk) begin
        #1;
        if (mem_ready) cnt = 0;
        if (mem_req && cnt == wait_n) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr[8:2]];
        end else begin
            mem_ready = 1'b0;
            cnt = mem_req ? cnt + 1 : 0;
        end
        mem_rdata_b = memb[mem_addr_b[8:2]];
    end

    always @(negedge clk) begin
        cyc++;
        if (reset && mem_req && first_fetch < 0) first_fetch = cyc;
        if (retire) begin
            retire_cyc.push_back(cyc);
            retire_cnt++;
            if (retire_cnt == 3) wait_n = 3;
        end
        if (retire_b) retire_b_cnt++;
        if (reset && p_req && !p_ready) begin
            check("req_held", {31'd0, mem_req}, 32'd1);
            check("addr_stable", mem_addr, p_addr);
            check("we_stable", {31'd0, mem_we}, {31'd0, p_we});
            if (p_we) check("wdata_stable", mem_wdata, p_wdata);
        end
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                mem[mem_addr[8:2]] = mem_wdata;
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
            end else begin
                rd_addr.push_back(mem_addr);
            end
        end
        p_req   = mem_req;
        p_ready = mem_ready;
        p_we    = mem_we;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
    end

    initial begin
        reset       = 1'b0;
        reset_b     = 1'b0;
        mem_ready   = 1'b0;
        mem_rdata   = 32'd0;
        mem_ready_b = 1'b1;
        mem_rdata_b = 32'd0;
        for (int i = 0; i < 128; i++) begin
            mem[i]  = 32'd0;
            memb[i] = 32'd0;
        end
        mem[32'h100 >> 2] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
        mem[32'h104 >> 2] = enc_i(32'd7, 5'd0, 3'b000, 5'd2, 7'b0010011);
        mem[32'h108 >> 2] = enc_r(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
        mem[32'h10C >> 2] = enc_j(-32'sd252, 5'd0);
        mem[32'h010 >> 2] = enc_b(32'd8, 5'd1, 5'd1);
        mem[32'h014 >> 2] = enc_i(32'd1, 5'd0, 3'b000, 5'd7, 7'b0010011);
        mem[32'h018 >> 2] = enc_j(-32'sd16, 5'd5);
        mem[32'h008 >> 2] = enc_s(32'd8, 5'd3, 5'd0);
        mem[32'h00C >> 2] = enc_j(32'h34, 5'd0);
        mem[32'h040 >> 2] = enc_i(32'd8, 5'd0, 3'b010, 5'd4, 7'b0000011);
        mem[32'h044 >> 2] = enc_i(32'd2, 5'd0, 3'b010, 5'd6, 7'b0000011);
        memb[0] = enc_i(32'd3, 5'd0, 3'b000, 5'd1, 7'b0010011);
        memb[1] = enc_i(32'd9, 5'd0, 3'b000, 5'd0, 7'b0010011);
        memb[2] = enc_r(7'd0, 5'd0, 5'd0, 3'b000, 5'd1);
        memb[3] = enc_i(32'd1, 5'd0, 3'b000, 5'd20, 7'b0010011);
        exp_rd = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h010, 32'h018,
                   32'h008, 32'h00C, 32'h040, 32'h008, 32'h044};

        repeat (3) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_trap", {31'd0, trap}, 32'd0);
        check("rst_retire", {31'd0, retire}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("first_req", {31'd0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h100);
        check("first_trap", {31'd0, trap}, 32'd0);

        for (int i = 0; i < 800; i++) begin
            if (trap) break;
            @(negedge clk);
        end
        check("trap_a", {31'd0, trap}, 32'd1);
        repeat (10) @(negedge clk);
        check("trap_sticky", {31'd0, trap}, 32'd1);
        check("trap_no_req", {31'd0, mem_req}, 32'd0);
        check("retire_count", retire_cnt, 32'd9);
        check("retire_q_size", retire_cyc.size(), 32'd9);
        if (retire_cyc.size() >= 3)
            check("third_retire_cycle", retire_cyc[2] - first_fetch, 32'd11);
        check("x1", dut_a.rf[1], 32'd5);
        check("x2", dut_a.rf[2], 32'd7);
        check("x3", dut_a.rf[3], 32'd12);
        check("x4", dut_a.rf[4], 32'd12);
        check("x5", dut_a.rf[5], 32'h1C);
        check("x6_untouched", dut_a.rf[6], 32'd0);
        check("x7_skipped", dut_a.rf[7], 32'd0);
        check("x0", dut_a.rf[0], 32'd0);
        check("write_count", wr_addr.size(), 32'd1);
        if (wr_addr.size() >= 1) begin
            check("write_addr", wr_addr[0], 32'd8);
            check("write_data", wr_data[0], 32'd12);
        end
        check("read_count", rd_addr.size(), 32'd11);
        for (int i = 0; i < 11 && i < rd_addr.size(); i++)
            check($sformatf("read_addr_%0d", i), rd_addr[i], exp_rd[i]);

        reset = 1'b0;
        mem[32'h100 >> 2] = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        check("rst2_trap", {31'd0, trap}, 32'd0);
        check("rst2_x3_cleared", dut_a.rf[3], 32'd0);
        check("rst2_mem_req", {31'd0, mem_req}, 32'd0);
        saved_ret = retire_cnt;
        reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (trap) break;
            @(negedge clk);
        end
        check("illegal_trap", {31'd0, trap}, 32'd1);
        repeat (5) @(negedge clk);
        check("illegal_no_retire", retire_cnt, saved_ret);
        check("illegal_no_req", {31'd0, mem_req}, 32'd0);
        check("illegal_x1", dut_a.rf[1], 32'd0);

        reset   = 1'b0;
        reset_b = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (trap_b) break;
            @(negedge clk);
        end
        check("rv32e_trap", {31'd0, trap_b}, 32'd1);
        repeat (3) @(negedge clk);
        check("rv32e_retires", retire_b_cnt, 32'd3);
        check("rv32e_x1", dut_b.rf[1], 32'd0);
        check("rv32e_x0", dut_b.rf[0], 32'd0);
        check("rv32e_no_req", {31'd0, mem_req_b}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
